// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Brief    : Opcodes, PSR bit positions and sequencer states for alu_arbiter.
// Revision : 1.0
// ============================================================================
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_OR  = 3'b100;
    localparam logic [2:0] ALU_CMP = 3'b101;

    localparam int PSR_C = 0;
    localparam int PSR_F = 1;
    localparam int PSR_L = 2;
    localparam int PSR_Z = 3;
    localparam int PSR_N = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic logic op_is_valid(input logic [2:0] op);
        return op <= ALU_CMP;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter_if
// Brief    : Request/response/ALU bundle; slave is the arbiter, master the rest.
// Revision : 1.0
// ============================================================================
interface alu_arbiter_if #(
    parameter int WIDTH = 16
);
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req0_b;
    logic [WIDTH-1:0] req1_b;
    logic [2:0]       req0_op;
    logic [2:0]       req1_op;
    logic             req0_setpsr;
    logic             req1_setpsr;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [WIDTH-1:0] rsp_result;
    logic [4:0]       rsp_psr;
    logic             rsp_err;
    logic [WIDTH-1:0] alu_rsrc;
    logic [WIDTH-1:0] alu_rdest;
    logic [2:0]       alu_cont;
    logic [WIDTH-1:0] alu_result;
    logic [4:0]       alu_psr;
    logic [4:0]       psr_q;

    modport slave (
        input  req_valid, req0_a, req1_a, req0_b, req1_b, req0_op, req1_op,
               req0_setpsr, req1_setpsr, rsp_ready, alu_result, alu_psr,
        output req_ready, rsp_valid, rsp_result, rsp_psr, rsp_err,
               alu_rsrc, alu_rdest, alu_cont, psr_q
    );

    modport master (
        output req_valid, req0_a, req1_a, req0_b, req1_b, req0_op, req1_op,
               req0_setpsr, req1_setpsr, rsp_ready, alu_result, alu_psr,
        input  req_ready, rsp_valid, rsp_result, rsp_psr, rsp_err,
               alu_rsrc, alu_rdest, alu_cont, psr_q
    );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Two-way round-robin grant with a priority pointer register.
// Revision : 1.0
// ============================================================================
module rr_arbiter2 (
    input  wire logic       clk,
    input  wire logic       reset_n,
    input  wire logic [1:0] req,
    input  wire logic       advance,
    input  wire logic       served,
    output logic      [1:0] grant
);
    logic r_ptr;

    // Priority moves to whichever requester was not just served.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ptr <= 1'b0;
        end else if (advance) begin
            r_ptr <= ~served;
        end
    end

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = r_ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Brief    : Shares one combinational ALU between two requesters; owns the PSR.
// Revision : 1.0
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  wire logic     clk,
    input  wire logic     reset_n,
    alu_arbiter_if.slave  bus
);
    state_t           r_state;
    state_t           w_next;
    logic [1:0]       w_grant;
    logic             w_accept;
    logic             w_done;
    logic             w_op_ok;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic             r_setpsr;
    logic             r_gidx;
    logic [WIDTH-1:0] r_result;
    logic [4:0]       r_rsp_psr;
    logic             r_err;
    logic [4:0]       r_psr;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (bus.req_valid),
        .advance (w_done),
        .served  (r_gidx),
        .grant   (w_grant)
    );

    assign w_accept = (r_state == ST_IDLE) && (|w_grant);
    assign w_done   = (r_state == ST_RESP) && bus.rsp_ready[r_gidx];
    assign w_op_ok  = op_is_valid(r_op);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_EXEC;
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: if (w_done) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= ALU_ADD;
            r_setpsr  <= 1'b0;
            r_gidx    <= 1'b0;
            r_result  <= '0;
            r_rsp_psr <= '0;
            r_err     <= 1'b0;
            r_psr     <= '0;
        end else begin
            if (w_accept) begin
                r_a      <= w_grant[1] ? bus.req1_a      : bus.req0_a;
                r_b      <= w_grant[1] ? bus.req1_b      : bus.req0_b;
                r_op     <= w_grant[1] ? bus.req1_op     : bus.req0_op;
                r_setpsr <= w_grant[1] ? bus.req1_setpsr : bus.req0_setpsr;
                r_gidx   <= w_grant[1];
            end
            // Invalid opcodes never reach the ALU; report a zeroed error response.
            if (r_state == ST_EXEC) begin
                r_result  <= w_op_ok ? bus.alu_result : '0;
                r_rsp_psr <= w_op_ok ? bus.alu_psr    : '0;
                r_err     <= ~w_op_ok;
                if (w_op_ok && r_setpsr) begin
                    r_psr <= bus.alu_psr;
                end
            end
        end
    end

    assign bus.req_ready  = (r_state == ST_IDLE) ? w_grant : 2'b00;
    assign bus.rsp_valid  = (r_state == ST_RESP) ? (r_gidx ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_result = r_result;
    assign bus.rsp_psr    = r_rsp_psr;
    assign bus.rsp_err    = r_err;
    assign bus.alu_rsrc   = r_a;
    assign bus.alu_rdest  = r_b;
    assign bus.alu_cont   = w_op_ok ? r_op : ALU_ADD;
    assign bus.psr_q      = r_psr;
endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_arbiter
// Brief    : Directed bench for alu_arbiter with a behavioural ALU alongside.
// Revision : 1.0
// ============================================================================
module tb_alu_arbiter;
    logic clk;
    logic reset_n;
    int   n_pass;
    int   n_fail;
    int   n_total;

    alu_arbiter_if #(.WIDTH(16)) bus ();

    alu_arbiter #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: flags {N,Z,L,F,C}; SUB/CMP compute rdest - rsrc.
    logic [15:0] m_a, m_b, m_r;
    logic        m_c, m_f, m_l;
    always_comb begin
        m_a = bus.alu_rsrc;
        m_b = bus.alu_rdest;
        m_r = 16'h0000;
        m_c = 1'b0;
        m_f = 1'b0;
        m_l = 1'b0;
        case (bus.alu_cont)
            3'b000: begin
                {m_c, m_r} = {1'b0, m_a} + {1'b0, m_b};
                m_f = (m_a[15] == m_b[15]) && (m_r[15] != m_a[15]);
            end
            3'b001: begin
                m_r = m_b - m_a;
                m_c = m_a > m_b;
            end
            3'b010: m_r = m_a & m_b;
            3'b011: m_r = m_a ^ m_b;
            3'b100: m_r = m_a | m_b;
            3'b101: begin
                m_r = m_b - m_a;
                m_l = m_b < m_a;
            end
            default: m_r = 16'h0000;
        endcase
        bus.alu_result = m_r;
        bus.alu_psr    = {m_r[15], (m_r == 16'h0000), m_l, m_f, m_c};
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int idx, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] op, input logic sp);
        if (idx == 0) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_setpsr = sp;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_setpsr = sp;
        end
    endtask

    // Entered and left 1 ns after a falling edge with the DUT in IDLE.
    task automatic run_op(input string tag, input int idx,
                          input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] op, input logic sp, input logic [2:0] exp_cont,
                          input logic [15:0] exp_res, input logic [4:0] exp_psr,
                          input logic exp_err, input logic [4:0] exp_psrq);
        logic [1:0] oh;
        oh = (idx == 0) ? 2'b01 : 2'b10;
        drive(idx, a, b, op, sp);
        bus.req_valid = oh;
        #1;
        chk({tag, ".req_ready"}, 32'(bus.req_ready), 32'(oh));
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        chk({tag, ".alu_cont"}, 32'(bus.alu_cont), 32'(exp_cont));
        chk({tag, ".exec_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        #1;
        chk({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(oh));
        chk({tag, ".rsp_result"}, 32'(bus.rsp_result), 32'(exp_res));
        chk({tag, ".rsp_psr"}, 32'(bus.rsp_psr), 32'(exp_psr));
        chk({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
        chk({tag, ".psr_q"}, 32'(bus.psr_q), 32'(exp_psrq));
        bus.rsp_ready = 2'b11;
        @(negedge clk);
        #1;
        bus.rsp_ready = 2'b00;
        chk({tag, ".idle_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_pass = 0; n_fail = 0; n_total = 0;
        reset_n = 1'b0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        drive(0, 16'h0, 16'h0, 3'b000, 1'b0);
        drive(1, 16'h0, 16'h0, 3'b000, 1'b0);

        // Reset values
        repeat (2) @(negedge clk);
        #1;
        chk("rst.req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst.rsp_result", 32'(bus.rsp_result), 32'd0);
        chk("rst.psr_q", 32'(bus.psr_q), 32'd0);
        chk("rst.alu_rsrc", 32'(bus.alu_rsrc), 32'd0);
        chk("rst.alu_cont", 32'(bus.alu_cont), 32'd0);
        reset_n = 1'b1;

        // ADD with carry out updates PSR
        run_op("add_carry", 0, 16'hFFFF, 16'h0001, 3'b000, 1'b1, 3'b000,
               16'h0000, 5'b01001, 1'b0, 5'b01001);

        // Both requesters held valid: strict alternation, one op per 3 cycles
        do_reset();
        drive(0, 16'h0001, 16'h0002, 3'b000, 1'b0);
        drive(1, 16'h00F0, 16'h0FF0, 3'b011, 1'b0);
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b11;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rr%0d.req_ready", k), 32'(bus.req_ready),
                (k % 2 == 1) ? 32'd2 : 32'd1);
            @(negedge clk); #1;
            chk($sformatf("rr%0d.exec_ready", k), 32'(bus.req_ready), 32'd0);
            @(negedge clk); #1;
            chk($sformatf("rr%0d.rsp_valid", k), 32'(bus.rsp_valid),
                (k % 2 == 1) ? 32'd2 : 32'd1);
            chk($sformatf("rr%0d.rsp_result", k), 32'(bus.rsp_result),
                (k % 2 == 1) ? 32'h0F00 : 32'h0003);
            @(negedge clk); #1;
        end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        chk("rr.psr_q", 32'(bus.psr_q), 32'd0);
        @(negedge clk); #1;

        // CMP equal sets Z; AND without setpsr leaves PSR alone
        run_op("cmp_eq", 0, 16'h0003, 16'h0003, 3'b101, 1'b1, 3'b101,
               16'h0000, 5'b01000, 1'b0, 5'b01000);
        run_op("and_nopsr", 1, 16'h00FF, 16'h0F0F, 3'b010, 1'b0, 3'b010,
               16'h000F, 5'b00000, 1'b0, 5'b01000);

        // Invalid opcode: error response, no PSR write, ALU sees 000
        run_op("bad_op", 1, 16'h0001, 16'h0001, 3'b110, 1'b1, 3'b000,
               16'h0000, 5'b00000, 1'b1, 5'b01000);

        // Back-pressure while requester 1 waits
        drive(0, 16'h0005, 16'h0006, 3'b000, 1'b0);
        drive(1, 16'h0101, 16'h1010, 3'b100, 1'b0);
        bus.req_valid = 2'b01;
        @(negedge clk);
        bus.req_valid = 2'b10;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("bp%0d.rsp_valid", k), 32'(bus.rsp_valid), 32'd1);
            chk($sformatf("bp%0d.rsp_result", k), 32'(bus.rsp_result), 32'h000B);
            chk($sformatf("bp%0d.req_ready", k), 32'(bus.req_ready), 32'd0);
            bus.rsp_ready = 2'b10;
            @(negedge clk);
        end
        bus.rsp_ready = 2'b01;
        #1;
        chk("bp.hs_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk); #1;
        bus.rsp_ready = 2'b00;
        chk("bp.req1_ready", 32'(bus.req_ready), 32'd2);
        @(negedge clk); #1;
        bus.req_valid = 2'b00;
        @(negedge clk); #1;
        chk("bp.req1_rsp_valid", 32'(bus.rsp_valid), 32'd2);
        chk("bp.req1_result", 32'(bus.rsp_result), 32'h1111);
        bus.rsp_ready = 2'b10;
        @(negedge clk); #1;
        bus.rsp_ready = 2'b00;

        // Reset during EXEC aborts the operation and restores priority 0
        drive(1, 16'hFFFF, 16'h0001, 3'b000, 1'b1);
        bus.req_valid = 2'b10;
        @(negedge clk);
        bus.req_valid = 2'b00;
        #1;
        chk("rexec.alu_rsrc", 32'(bus.alu_rsrc), 32'hFFFF);
        reset_n = 1'b0;
        @(negedge clk); #1;
        chk("rexec.rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rexec.rsp_result", 32'(bus.rsp_result), 32'd0);
        chk("rexec.rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rexec.psr_q", 32'(bus.psr_q), 32'd0);
        chk("rexec.alu_rsrc0", 32'(bus.alu_rsrc), 32'd0);
        chk("rexec.alu_cont", 32'(bus.alu_cont), 32'd0);
        @(negedge clk); #1;
        chk("rexec.post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        reset_n = 1'b1;
        drive(0, 16'h0001, 16'h0002, 3'b000, 1'b0);
        bus.req_valid = 2'b11;
        #1;
        chk("rexec.prio0", 32'(bus.req_ready), 32'd1);
        @(negedge clk);
        bus.req_valid = 2'b00;
        @(negedge clk); #1;
        chk("rexec.rsp_valid0", 32'(bus.rsp_valid), 32'd1);
        chk("rexec.result0", 32'(bus.rsp_result), 32'h0003);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
